// File: rtl/button_encoder_if.sv
// Button-side bus of button_encoder: raw buttons in, debounced levels and encoded press events out.
// The master modport is the encoder; the slave modport is the board/consumer side.
interface button_encoder_if;
    logic [3:0] btn;
    logic [3:0] pressed;
    logic [1:0] code;
    logic       code_valid;
    logic       repeat_evt;
    logic       collision;

    modport master (
        input  btn,
        output pressed,
        output code,
        output code_valid,
        output repeat_evt,
        output collision
    );

    modport slave (
        output btn,
        input  pressed,
        input  code,
        input  code_valid,
        input  repeat_evt,
        input  collision
    );
endinterface

// File: rtl/button_encoder.sv
// Sync + debounce four buttons and encode each new press as a 2-bit index strobe; AUTO_REPEAT_EN adds hold auto-repeat.
// Latency: code_valid DEBOUNCE_CYCLES+2 edges after the first edge that samples a steady new level.
// No backpressure: code_valid is a one-cycle strobe and code holds until the next event.
module button_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 24,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    button_encoder_if.master bus
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       r_s1;
    logic [3:0]       r_s2;
    logic [3:0]       r_pressed;
    logic [3:0]       r_pressed_d;
    logic [CNT_W-1:0] r_db_cnt [4];
    logic [1:0]       r_code;
    logic             r_code_valid;
    logic             r_repeat_evt;
    logic             r_collision;

    logic [3:0]       w_rise;
    logic [1:0]       w_rise_idx;
    logic             w_multi;
    logic             w_rpt_fire;
    logic [1:0]       w_rpt_idx;

    // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_pressed   <= '0;
            r_pressed_d <= '0;
            for (int i = 0; i < 4; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_s1        <= bus.btn;
            r_s2        <= r_s1;
            r_pressed_d <= r_pressed;
            for (int i = 0; i < 4; i++) begin
                if (r_s2[i] == r_pressed[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] < DB_LAST) begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
                end else begin
                    r_pressed[i] <= ~r_pressed[i];
                    r_db_cnt[i]  <= '0;
                end
            end
        end
    end

    assign w_rise  = r_pressed & ~r_pressed_d;
    assign w_multi = (w_rise & (w_rise - 4'd1)) != 4'd0;

    always_comb begin
        w_rise_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_rise[i]) begin
                w_rise_idx = 2'(i);
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    rpt_state_t       r_rpt_state;
    rpt_state_t       w_rpt_state_nxt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic [1:0]       r_rpt_idx;
    logic [1:0]       w_rpt_idx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_state <= RPT_IDLE;
            r_rpt_cnt   <= '0;
            r_rpt_idx   <= '0;
        end else begin
            r_rpt_state <= w_rpt_state_nxt;
            r_rpt_cnt   <= w_rpt_cnt_nxt;
            r_rpt_idx   <= w_rpt_idx_nxt;
        end
    end

    // A fresh press always wins over a repeat due on the same edge.
    always_comb begin
        w_rpt_state_nxt = r_rpt_state;
        w_rpt_cnt_nxt   = r_rpt_cnt;
        w_rpt_idx_nxt   = r_rpt_idx;
        w_rpt_fire      = 1'b0;
        if (w_rise != 4'd0) begin
            w_rpt_state_nxt = RPT_DELAY;
            w_rpt_cnt_nxt   = '0;
            w_rpt_idx_nxt   = w_rise_idx;
        end else begin
            case (r_rpt_state)
                RPT_DELAY, RPT_REPEAT: begin
                    if (!r_pressed[r_rpt_idx]) begin
                        w_rpt_state_nxt = RPT_IDLE;
                        w_rpt_cnt_nxt   = '0;
                    end else if (r_rpt_cnt == ((r_rpt_state == RPT_DELAY) ? RD_LAST : RP_LAST)) begin
                        w_rpt_fire      = 1'b1;
                        w_rpt_state_nxt = RPT_REPEAT;
                        w_rpt_cnt_nxt   = '0;
                    end else begin
                        w_rpt_cnt_nxt   = r_rpt_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_rpt_state_nxt = RPT_IDLE;
                end
            endcase
        end
    end

    assign w_rpt_idx = r_rpt_idx;
`else
    assign w_rpt_fire = 1'b0;
    assign w_rpt_idx  = 2'd0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_repeat_evt <= 1'b0;
            r_collision  <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            r_repeat_evt <= 1'b0;
            r_collision  <= 1'b0;
            if (w_rise != 4'd0) begin
                r_code_valid <= 1'b1;
                r_code       <= w_rise_idx;
                r_collision  <= w_multi;
            end else if (w_rpt_fire) begin
                r_code_valid <= 1'b1;
                r_repeat_evt <= 1'b1;
                r_code       <= w_rpt_idx;
            end
        end
    end

    assign bus.pressed    = r_pressed;
    assign bus.code       = r_code;
    assign bus.code_valid = r_code_valid;
    assign bus.repeat_evt = r_repeat_evt;
    assign bus.collision  = r_collision;
endmodule

// File: tb/tb_button_encoder.sv
// Randomised and directed bench for button_encoder against a timestamp-based behavioural model.
module tb_button_encoder;
    localparam int D  = 8;
    localparam int RD = 16;
    localparam int RP = 6;

    logic clk;
    logic reset;
    button_encoder_if bus_if ();

    button_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(24),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int cyc      = 0;
    bit chk_en   = 0;

    // Model state: debounced level, mismatch streak length, and absolute time of the next repeat.
    logic [3:0] m_s1 = 0, m_s2 = 0, m_deb = 0, m_deb_d = 0;
    int         m_streak [4] = '{0, 0, 0, 0};
    logic [1:0] m_code = 0;
    logic       m_cv = 0, m_rep = 0, m_col = 0;
    bit         rpt_on = 0;
    logic [1:0] rpt_idx = 0;
    int         rpt_next = 0;

    int         ev_cyc [$];
    logic [1:0] ev_code [$];
    logic       ev_rep [$];
    logic       ev_col [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [1:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
        return 2'd0;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] rise;
        cyc++;
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_d = 0;
            for (int i = 0; i < 4; i++) m_streak[i] = 0;
            m_code = 0; m_cv = 0; m_rep = 0; m_col = 0; rpt_on = 0;
        end else begin
            rise  = m_deb & ~m_deb_d;
            m_cv  = 0;
            m_rep = 0;
            m_col = 0;
            if (rise != 0) begin
                m_cv   = 1;
                m_code = lowest(rise);
                m_col  = ($countones(rise) >= 2);
                rpt_on   = 1;
                rpt_idx  = m_code;
                rpt_next = cyc + RD;
            end else if (rpt_on) begin
`ifdef AUTO_REPEAT_EN
                if (!m_deb[rpt_idx]) rpt_on = 0;
                else if (cyc == rpt_next) begin
                    m_cv = 1; m_rep = 1; m_code = rpt_idx; rpt_next = cyc + RP;
                end
`else
                rpt_on = 0;
`endif
            end
            m_deb_d = m_deb;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_deb[i]) m_streak[i] = 0;
                else begin
                    m_streak[i]++;
                    if (m_streak[i] == D) begin
                        m_deb[i] = ~m_deb[i];
                        m_streak[i] = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = bus_if.btn;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pressed", 32'(bus_if.pressed), 32'(m_deb));
            check("code", 32'(bus_if.code), 32'(m_code));
            check("code_valid", 32'(bus_if.code_valid), 32'(m_cv));
            check("repeat_evt", 32'(bus_if.repeat_evt), 32'(m_rep));
            check("collision", 32'(bus_if.collision), 32'(m_col));
            if (bus_if.code_valid === 1'b1) begin
                ev_cyc.push_back(cyc);
                ev_code.push_back(bus_if.code);
                ev_rep.push_back(bus_if.repeat_evt);
                ev_col.push_back(bus_if.collision);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n0, base, bounced;
        bus_if.btn = 4'b0000;
        reset = 1'b1;
        @(posedge clk); #2;
        chk_en = 1;
        step(2);
        @(negedge clk);
        check("rst_pressed", 32'(bus_if.pressed), 0);
        check("rst_code_valid", 32'(bus_if.code_valid), 0);
        check("rst_collision", 32'(bus_if.collision), 0);
        step(1);
        reset = 1'b0;
        step(2);

        // Basic press on bit 2
        n0 = ev_cyc.size(); base = cyc + 1;
        bus_if.btn = 4'b0100;
        step(30);
        check("basic_count", ev_cyc.size() - n0, 1);
        if (ev_cyc.size() > n0) begin
            check("basic_latency", ev_cyc[n0] - base, D + 2);
            check("basic_code", 32'(ev_code[n0]), 2);
            check("basic_col", 32'(ev_col[n0]), 0);
        end
        check("basic_pressed", 32'(bus_if.pressed), 32'h4);
        n0 = ev_cyc.size();
        bus_if.btn = 4'b0000;
        step(20);
        check("release_count", ev_cyc.size() - n0, 0);

        // Bounce on bit 1, toggling every 5 cycles, then steady
        n0 = ev_cyc.size(); bounced = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) bus_if.btn[1] = ~bus_if.btn[1];
            @(negedge clk);
            if (bus_if.pressed[1]) bounced++;
            step(1);
        end
        check("bounce_pressed", bounced, 0);
        check("bounce_events", ev_cyc.size() - n0, 0);
        base = cyc + 1;
        bus_if.btn[1] = 1'b1;
        step(30);
        check("bounce_count", ev_cyc.size() - n0, 1);
        if (ev_cyc.size() > n0) begin
            check("bounce_latency", ev_cyc[n0] - base, D + 2);
            check("bounce_code", 32'(ev_code[n0]), 1);
        end
        bus_if.btn = 4'b0000;
        step(20);

        // Collision: bits 1 and 3 together
        n0 = ev_cyc.size();
        bus_if.btn = 4'b1010;
        step(30);
        bus_if.btn = 4'b0000;
        step(20);
        check("coll_count", ev_cyc.size() - n0, 1);
        if (ev_cyc.size() > n0) begin
            check("coll_code", 32'(ev_code[n0]), 1);
            check("coll_flag", 32'(ev_col[n0]), 1);
        end

        // Release and re-press bit 3
        n0 = ev_cyc.size();
        bus_if.btn = 4'b1000; step(20);
        bus_if.btn = 4'b0000; step(20);
        bus_if.btn = 4'b1000; step(20);
        bus_if.btn = 4'b0000; step(20);
        check("repress_count", ev_cyc.size() - n0, 2);
        if (ev_cyc.size() > n0 + 1) begin
            check("repress_code0", 32'(ev_code[n0]), 3);
            check("repress_code1", 32'(ev_code[n0 + 1]), 3);
        end

        // One-cycle reset in mid-debounce with bit 0 held
        n0 = ev_cyc.size();
        bus_if.btn = 4'b0001;
        step(4);
        reset = 1'b1;
        step(1);
        @(negedge clk);
        check("midrst_pressed", 32'(bus_if.pressed), 0);
        check("midrst_code", 32'(bus_if.code), 0);
        check("midrst_valid", 32'(bus_if.code_valid), 0);
        reset = 1'b0;
        base = cyc + 1;
        step(30);
        check("midrst_count", ev_cyc.size() - n0, 1);
        if (ev_cyc.size() > n0) begin
            check("midrst_latency", ev_cyc[n0] - base, D + 2);
            check("midrst_code_ev", 32'(ev_code[n0]), 0);
        end
        bus_if.btn = 4'b0000;
        step(20);

        // Long hold on bit 2 for 50 cycles
        n0 = ev_cyc.size(); base = cyc + 1;
        bus_if.btn = 4'b0100;
        step(50);
        bus_if.btn = 4'b0000;
        step(30);
`ifdef AUTO_REPEAT_EN
        // Press at base+10, repeats at +16 then every 6 until pressed[2] falls at base+59: six repeats.
        check("hold_count", ev_cyc.size() - n0, 7);
        if (ev_cyc.size() >= n0 + 7) begin
            check("hold_first_rep", 32'(ev_rep[n0]), 0);
            for (int j = 0; j < 6; j++) begin
                check("hold_rep_time", ev_cyc[n0 + 1 + j] - base, D + 2 + RD + RP * j);
                check("hold_rep_flag", 32'(ev_rep[n0 + 1 + j]), 1);
                check("hold_rep_code", 32'(ev_code[n0 + 1 + j]), 2);
            end
        end
`else
        check("hold_count", ev_cyc.size() - n0, 1);
        if (ev_cyc.size() > n0) check("hold_rep_flag", 32'(ev_rep[n0]), 0);
`endif

        // Random phases: fast chatter, then slower holds with occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, (c < 2000) ? 11 : 45) == 0) bus_if.btn[b] = ~bus_if.btn[b];
            end
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        bus_if.btn = 4'b0000;
        step(40);
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
